// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// master drives requests; slave is the FIFO itself.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [AW:0]           count;
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, data_in, r_en, err_clr,
        input  data_out, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en, err_clr,
        output data_out, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, fill count and sticky errors.
// Define SYNC_FIFO_PARAM_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic               clk,
    input  logic               arst,
    sync_fifo_param_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic [AW:0]           cnt;
    logic                  ovf;
    logic                  unf;
    logic                  is_full;
    logic                  is_empty;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [AW-1:0]         widx;
    logic [AW-1:0]         ridx;

    // Flags come from the registered count only, never from w_en/r_en.
    assign is_full  = (cnt == DEPTH_C);
    assign is_empty = (cnt == '0);
    assign wr_ok    = bus.w_en && !is_full;
    assign rd_ok    = bus.r_en && !is_empty;
    assign widx     = wptr[AW-1:0];
    assign ridx     = rptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[widx] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + ONE;
                2'b01:   cnt <= cnt - ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // A new error at the same edge as err_clr stays set.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (bus.w_en && is_full) begin
                ovf <= 1'b1;
            end else if (bus.err_clr) begin
                ovf <= 1'b0;
            end
            if (bus.r_en && is_empty) begin
                unf <= 1'b1;
            end else if (bus.err_clr) begin
                unf <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_PARAM_FWFT_EN
    assign bus.data_out = is_empty ? '0 : mem[ridx];
`else
    logic [DATA_WIDTH-1:0] dout;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dout <= '0;
        end else if (rd_ok) begin
            dout <= mem[ridx];
        end
    end

    assign bus.data_out = dout;
`endif

    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (cnt >= AF_C);
    assign bus.almost_empty = (cnt <= AE_C);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;
endmodule
